// File: rtl/mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl
//
// E-stage issue and hazard controller for the HI/LO multiply-divide unit.
// It holds the MD-class opcode in a D->E register and decodes it into the
// MDU start/op strobes, the HI/LO write strobes and the mfhi/mflo result
// select. It also mirrors the MDU countdown, so any MD-class instruction
// waiting in D is stalled while a multiply or divide is in flight.
//
// Parameters
//   MULT_CYC       cycles from the start edge to the HI/LO update (mult/multu)
//   DIV_CYC        cycles from the start edge to the HI/LO update (div/divu)
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   reset          synchronous active-high reset, clears all state
//   d_md_op        D-stage MD class (0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                  5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 behave as NONE)
//   ext_stall      stall request from other hazard logic (bubble into E)
//   mdu_busy       busy indication from the MDU, used only for cross-check
//   mdu_start      one-cycle start strobe to the MDU
//   mdu_op         MDU operation (0 mult, 1 multu, 2 div, 3 divu), 0 if idle
//   mdu_hi_write   mthi is in E
//   mdu_lo_write   mtlo is in E
//   e_mf_hi        mfhi is in E, E result mux selects HI
//   e_mf_lo        mflo is in E, E result mux selects LO
//   md_stall       combinational stall for F/D hold plus an E bubble
//   busy_mismatch  sticky flag, internal busy view disagreed with mdu_busy
// ---------------------------------------------------------------------------
module mdu_issue_ctrl #(
    parameter int MULT_CYC = 4,
    parameter int DIV_CYC  = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d_md_op,
    input  logic       ext_stall,
    input  logic       mdu_busy,
    output logic       mdu_start,
    output logic [2:0] mdu_op,
    output logic       mdu_hi_write,
    output logic       mdu_lo_write,
    output logic       e_mf_hi,
    output logic       e_mf_lo,
    output logic       md_stall,
    output logic       busy_mismatch
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    md_op_e     e_op_q;
    md_op_e     e_op_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       busy_mismatch_q;
    logic       busy_mismatch_d;

    logic       d_is_md;
    logic       cnt_running;
    logic       busy_int;
    logic       e_is_mult;
    logic [3:0] e_op_minus1;

    // Decode of the opcode held in E. Only the four arithmetic classes start
    // the unit; their MDU op code is simply the class number minus one.
    always_comb begin
        mdu_start    = 1'b0;
        mdu_op       = 3'd0;
        e_is_mult    = 1'b0;
        e_op_minus1  = 4'(e_op_q) - 4'd1;
        mdu_hi_write = (e_op_q == OP_MTHI);
        mdu_lo_write = (e_op_q == OP_MTLO);
        e_mf_hi      = (e_op_q == OP_MFHI);
        e_mf_lo      = (e_op_q == OP_MFLO);
        case (e_op_q)
            OP_MULT, OP_MULTU: begin
                mdu_start = 1'b1;
                mdu_op    = e_op_minus1[2:0];
                e_is_mult = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                mdu_start = 1'b1;
                mdu_op    = e_op_minus1[2:0];
            end
            default: begin
                mdu_start = 1'b0;
            end
        endcase
    end

    // Hazard detection. The unit counts as busy both in the start cycle
    // (start not yet sampled) and while the mirrored countdown is non-zero.
    // Only genuine MD-class instructions wait; NONE and the undefined codes
    // 9-15 pass straight through even while the unit is busy.
    always_comb begin
        d_is_md     = (d_md_op >= 4'd1) && (d_md_op <= 4'd8);
        cnt_running = (cnt_q != 4'd0);
        busy_int    = mdu_start | cnt_running;
        md_stall    = d_is_md & busy_int;
    end

    // Next-state for the E register. Any stall, from here or from other
    // hazard logic, injects a single bubble; undefined codes load as NONE so
    // they can never produce a strobe.
    always_comb begin
        e_op_d = OP_NONE;
        if (md_stall || ext_stall) begin
            e_op_d = OP_NONE;
        end else if (d_is_md) begin
            e_op_d = md_op_e'(d_md_op);
        end
    end

    // Countdown mirroring the MDU. It loads on the start edge and reaches
    // zero on the edge where the unit writes HI/LO, so a dependent
    // instruction is released into E exactly when the new values exist.
    // It keeps running during external stalls.
    always_comb begin
        cnt_d = cnt_q;
        if (mdu_start) begin
            cnt_d = e_is_mult ? MULT_LOAD : DIV_LOAD;
        end else if (cnt_running) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Cross-check against the unit. The registered countdown is the view
    // the MDU's own busy should match; the start cycle is skipped because the
    // unit has not yet seen the start there. Once set, only reset clears it.
    always_comb begin
        busy_mismatch_d = busy_mismatch_q;
        if (!mdu_start && (cnt_running != mdu_busy)) begin
            busy_mismatch_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_op_q          <= OP_NONE;
            cnt_q           <= 4'd0;
            busy_mismatch_q <= 1'b0;
        end else begin
            e_op_q          <= e_op_d;
            cnt_q           <= cnt_d;
            busy_mismatch_q <= busy_mismatch_d;
        end
    end

    assign busy_mismatch = busy_mismatch_q;

endmodule
